popcount21_pattern_gen: RTL and testbench
=========================================

Name: popcount21_pattern_gen

Overview:
Inverse of the 21-input popcount: takes a target count k (0..21) and streams every 21-bit word whose popcount is exactly k, in ascending numeric order, over a valid/ready interface. Feeds the characterisation bench and on-chip BIST for the approximate popcount21 family. Exhaustive per-count-class stimulus lets each class's error (MAE/WCE) be measured without sweeping all 2^21 inputs.

Parameters:
N_IN, 21, word width and maximum legal count
CNT_W, 5, width of the count field (ceil(log2(N_IN+1)))
IDX_W, 19, sequence index width (C(21,10)=352716 < 2^19)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  new count request
cmd_ready  out  1  high only in IDLE
cmd_count  in  CNT_W  target popcount k
abort  in  1  synchronous stop of current sequence
out_valid  out  1  out_word valid
out_ready  in  1  consumer accepts word
out_word  out  N_IN  current pattern, popcount == k
out_index  out  IDX_W  0-based position of out_word in sequence
out_last  out  1  out_word is final pattern for k
err  out  1  one-cycle pulse: illegal count rejected

Behaviour:
- Interface: one clock, clk; synchronous active-low reset, rst_n.
- Reset (rst_n=0 at an edge): state=IDLE, out_valid=0, out_word=0, out_index=0, out_last=0, err=0, cmd_ready=1 from next cycle. Reset mid-sequence discards it; no further words.
- FSM states: IDLE, RUN.
- IDLE: cmd_ready=1, out_valid=0. On cmd_valid&cmd_ready:
  - k<=21: latch k, out_word=(1<<k)-1, out_index=0, go RUN. First word is valid the cycle after acceptance (latency 1).
  - k>21: err=1 for exactly one cycle, stay IDLE, out_word unchanged.
- RUN: out_valid=1, cmd_ready=0 (cmd_valid ignored). On out_valid&out_ready:
  - out_last=1: go IDLE; out_valid=0 next cycle; out_word/out_index hold last value.
  - else: out_word=next(out_word), out_index+=1. Throughput is 1 word/cycle while out_ready=1.
- Backpressure: with out_ready=0, out_word, out_index and out_last hold stable.
- next(x) is Gosper successor, combinational, single cycle, no divider:
  - c = x & -x; r = x + c (N_IN+1 bits).
  - next = r | (((x ^ r) >> 2) >> ctz(c)).
- out_last is combinational from the latched k and out_word: 1 when out_word == ((1<<k)-1) << (N_IN-k).
  - k=0: single word 0; out_last=1 at index 0.
  - k=21: single word 0x1FFFFF; out_last=1 at index 0.
- Sequence length is C(21,k). out_index never wraps; its maximum is 352715.
- abort is sampled every cycle, in any state. In RUN it forces IDLE next cycle with out_valid=0; a handshake in the same cycle counts as consumed. abort has priority over cmd acceptance in IDLE: the command is ignored and cmd_ready stays 1.
- No X on outputs at any time after reset.

Decomposition:
- popcount21_pkg holds N_IN, CNT_W, IDX_W, the state enum (IDLE, RUN), and functions low_mask(k) and top_mask(k).
- Sub-module popcount21_gosper_next: purely combinational, in x[N_IN-1:0], out nx. Contains the lowest-set isolate, the adder, the ctz priority encoder and the barrel shifter.
- The top level holds the FSM, registers, handshake and last detect.

Test Plan:
- k=0, out_ready=1 -> one word 0x000000, index 0, out_last=1; cmd_ready=1 two cycles after acceptance.
- k=2, out_ready=1 -> 210 words: 0x000003, 0x000005, 0x000006, 0x000009, ...; final 0x180000 at index 209 with out_last=1. Each word strictly greater than the previous.
- k=10 exhaustive -> 352716 words, every popcount==10, no duplicates, final word 0x1FF800. Feed each word into popcount21_6w8j and accumulate |err|, cross-checked against the software model.
- k=22 -> err high exactly one cycle, out_valid never rises, cmd_ready stays 1.
- k=3 with out_ready toggled by random 30% stalls -> word/index stable across stalls; 1330 words delivered in order.
- k=5, abort at index 7 and separately rst_n=0 at index 7 -> out_valid=0 next cycle; a fresh k=1 command restarts at 0x000001, index 0.

Source files
------------

// File: rtl/popcount21_pkg.sv
// Shared constants, FSM state type and mask helpers for the popcount-21 pattern generator.
package popcount21_pkg;

  localparam int N_IN  = 21;
  localparam int CNT_W = 5;
  localparam int IDX_W = 19;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Smallest N_IN-bit word with popcount k: (1<<k)-1, valid for k in 0..N_IN.
  function automatic logic [N_IN-1:0] low_mask(input logic [CNT_W-1:0] k);
    logic [N_IN:0] m;
    m = ({{N_IN{1'b0}}, 1'b1} << k) - {{N_IN{1'b0}}, 1'b1};
    return m[N_IN-1:0];
  endfunction

  // Largest N_IN-bit word with popcount k: the k ones packed into the top bits.
  function automatic logic [N_IN-1:0] top_mask(input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] sh;
    sh = CNT_W'(N_IN) - k;
    return low_mask(k) << sh;
  endfunction

endpackage

// File: rtl/popcount21_gosper_next.sv
// Combinational Gosper successor: next larger word with the same popcount as x.
module popcount21_gosper_next
  import popcount21_pkg::*;
(
  input  logic [N_IN-1:0] x,
  output logic [N_IN-1:0] nx
);

  logic [N_IN-1:0]  c_s;
  logic [N_IN:0]    r_s;
  logic [N_IN:0]    diff_s;
  logic [N_IN:0]    tail_s;
  logic [CNT_W-1:0] ctz_s;

  // Isolate the lowest set bit and ripple it into the lowest block of ones.
  always_comb begin
    c_s = x & (~x + {{(N_IN-1){1'b0}}, 1'b1});
    r_s = {1'b0, x} + {1'b0, c_s};
  end

  // c_s is one-hot (or zero), so OR-ing the indices of its set bits gives ctz.
  always_comb begin
    ctz_s = {CNT_W{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      ctz_s = ctz_s | (c_s[i] ? CNT_W'(i) : {CNT_W{1'b0}});
    end
  end

  // Refill the displaced ones at the bottom of the word.
  always_comb begin
    diff_s = ({1'b0, x} ^ r_s) >> 2;
    tail_s = diff_s >> ctz_s;
    nx     = r_s[N_IN-1:0] | tail_s[N_IN-1:0];
  end

endmodule

// File: rtl/popcount21_pattern_gen.sv
// Streams every 21-bit word with popcount k in ascending order over valid/ready.
module popcount21_pattern_gen
  import popcount21_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  out_word,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             err
);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  word_q, word_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             err_q, err_d;
  logic [N_IN-1:0]  next_word_s;
  logic             last_s;

  popcount21_gosper_next u_next (
    .x  (word_q),
    .nx (next_word_s)
  );

  // Last detect is qualified by RUN so it stays low while idle.
  always_comb begin
    last_s = (state_q == ST_RUN) && (word_q == top_mask(k_q));
  end

  // Next-state logic: command acceptance, stream advance, abort.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    index_d = index_q;
    k_d     = k_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cmd_valid) begin
          if (cmd_count <= CNT_W'(N_IN)) begin
            k_d     = cmd_count;
            word_d  = low_mask(cmd_count);
            index_d = {IDX_W{1'b0}};
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (out_ready) begin
          if (last_s) begin
            state_d = ST_IDLE;
          end else begin
            word_d  = next_word_s;
            index_d = index_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= {N_IN{1'b0}};
      index_q <= {IDX_W{1'b0}};
      k_q     <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      index_q <= index_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == ST_RUN);
  assign cmd_ready = (state_q == ST_IDLE);
  assign out_word  = word_q;
  assign out_index = index_q;
  assign out_last  = last_s;
  assign err       = err_q;

endmodule

// File: tb/tb_popcount21_pattern_gen.sv
// Self-checking bench: table of count classes plus abort/reset/error corner sequences.
module tb_popcount21_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_count;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_word;
  logic [18:0] out_index;
  logic        out_last;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  popcount21_pattern_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_index (out_index),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    int          stall_pct;
    int          len;
    logic [20:0] final_word;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int binom(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (21 - i) / (i + 1);
    return r;
  endfunction

  function automatic logic [20:0] model_low(input int k);
    int v = (1 << k) - 1;
    return v[20:0];
  endfunction

  // Reference successor: scan upward for the next value with the same popcount.
  function automatic logic [20:0] model_next(input logic [20:0] x, input int k);
    int y = int'(x) + 1;
    while (y < (1 << 21) && $countones(y) != k) y++;
    return y[20:0];
  endfunction

  task automatic send_cmd(input int k);
    cmd_valid = 1'b1;
    cmd_count = k[4:0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Consume a full sequence from the negedge where the first word is due.
  task automatic run_seq(input int k, input int stall, output int n_words, output logic [20:0] last_word);
    logic [20:0] exp;
    int idx, total, budget;
    bit done, rdy;
    logic [63:0] got, want;
    exp = model_low(k); idx = 0; total = binom(k);
    n_words = 0; done = 0; budget = total * 4 + 100; last_word = '0;
    while (!done && budget > 0) begin
      got  = {21'd0, out_valid, cmd_ready, out_word, out_index, out_last};
      want = {21'd0, 1'b1, 1'b0, exp, idx[18:0], (idx == total - 1)};
      check("stream_word", got, want);
      check("popcount", 64'($countones(out_word)), 64'(k));
      rdy = ($urandom_range(99) >= stall);
      out_ready = rdy;
      cmd_valid = $urandom_range(1) != 0;
      cmd_count = 5'($urandom);
      @(posedge clk);
      if (rdy) begin
        n_words++;
        last_word = exp;
        if (idx == total - 1) done = 1;
        else begin
          exp = model_next(exp, k);
          idx++;
        end
      end
      @(negedge clk);
      budget--;
    end
    if (!done) check("seq_timeout", 64'(n_words), 64'(total));
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    check("idle_after_seq", {62'd0, out_valid, cmd_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  // Drive seven handshakes of k=5 so the bench sits at the negedge showing index 7.
  task automatic run_to_index7(output logic [20:0] exp);
    exp = model_low(5);
    send_cmd(5);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exp = model_next(exp, 5);
    end
    check("k5_index7", {24'd0, out_valid, out_word, out_index}, {24'd0, 1'b1, exp, 19'd7});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tab[8];
    int          nw;
    logic [20:0] lw, prev_word, e;
    int          picks[6];

    tab[0] = '{0,  0, 1,    21'h000000};
    tab[1] = '{1,  0, 21,   21'h100000};
    tab[2] = '{2,  0, 210,  21'h180000};
    tab[3] = '{3, 30, 1330, 21'h1C0000};
    tab[4] = '{4, 10, 5985, 21'h1E0000};
    tab[5] = '{17, 0, 5985, 21'h1FFFF0};
    tab[6] = '{20, 20, 21,  21'h1FFFFE};
    tab[7] = '{21, 0, 1,    21'h1FFFFF};
    picks = '{0, 1, 2, 19, 20, 21};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_count = 5'd0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {21'd0, out_valid, cmd_ready, out_word, out_index, out_last, err},
          {21'd0, 1'b0, 1'b1, 21'd0, 19'd0, 1'b0, 1'b0});

    prev_word = '0;
    foreach (tab[i]) begin
      send_cmd(tab[i].k);
      run_seq(tab[i].k, tab[i].stall_pct, nw, lw);
      check($sformatf("len_k%0d", tab[i].k), 64'(nw), 64'(tab[i].len));
      check($sformatf("final_k%0d", tab[i].k), 64'(lw), 64'(tab[i].final_word));
      prev_word = lw;
    end

    // Illegal counts: one-cycle err, no stream, word untouched.
    for (int k = 22; k <= 31; k += 9) begin
      send_cmd(k);
      check("err_pulse", {60'd0, err, out_valid, cmd_ready, 1'b0}, {60'd0, 1'b1, 1'b0, 1'b1, 1'b0});
      check("err_word_hold", 64'(out_word), 64'(prev_word));
      @(negedge clk);
      check("err_cleared", {61'd0, err, out_valid, cmd_ready}, {61'd0, 1'b0, 1'b0, 1'b1});
    end

    // Abort in IDLE beats a simultaneous command.
    cmd_valid = 1'b1; cmd_count = 5'd3; abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    check("abort_idle", {62'd0, out_valid, cmd_ready}, {62'd0, 1'b0, 1'b1});
    @(negedge clk);
    check("abort_idle_hold", {62'd0, out_valid, cmd_ready}, {62'd0, 1'b0, 1'b1});

    // Abort mid-sequence, then restart with k=1.
    run_to_index7(e);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    check("abort_run", {62'd0, out_valid, cmd_ready}, {62'd0, 1'b0, 1'b1});
    send_cmd(1);
    run_seq(1, 25, nw, lw);
    check("restart_after_abort", 64'(nw), 64'(21));

    // Reset mid-sequence, then restart with k=1.
    run_to_index7(e);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    check("reset_mid_seq", {21'd0, out_valid, cmd_ready, out_word, out_index, out_last, err},
          {21'd0, 1'b0, 1'b1, 21'd0, 19'd0, 1'b0, 1'b0});
    send_cmd(1);
    run_seq(1, 0, nw, lw);
    check("restart_after_reset", 64'(nw), 64'(21));

    // Randomised count classes and stall rates.
    for (int r = 0; r < 4; r++) begin
      int k, s;
      k = picks[$urandom_range(5)];
      s = $urandom_range(50);
      send_cmd(k);
      run_seq(k, s, nw, lw);
      check($sformatf("rand_len_k%0d", k), 64'(nw), 64'(binom(k)));
      check($sformatf("rand_final_k%0d", k), 64'(lw), 64'(model_low(k) << (21 - k)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
